// File: rtl/cache_port_arbiter_pkg.sv
// cache_arb_pkg: shared types and constants for the cache port arbiter.
//   arb_st_e  - per-port ownership state
//   PE0/PE1   - requester indices
//   cnt_w()   - width of the burst counter for a given MAX_BURST
package cache_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_st_e;
   localparam logic PE0 = 1'b0;
   localparam logic PE1 = 1'b1;
   function automatic int cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction
endpackage

// File: rtl/cache_port_arbiter_if.sv
// cache_port_arbiter_if: PE-side handshakes plus RAM-side ports of the arbiter.
//   slave  - seen by the arbiter (takes requests and RAM read data, drives grants and RAM controls)
//   master - seen by the PEs and the RAM
interface cache_port_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 19
);
   logic [1:0]            wr_req, wr_gnt, rd_req, rd_gnt, rd_valid;
   logic [ADDR_WIDTH-1:0] wr_addr0, wr_addr1, rd_addr0, rd_addr1;
   logic [DATA_WIDTH-1:0] wr_data0, wr_data1, rd_data;
   logic                  ram_wea;
   logic [ADDR_WIDTH-1:0] ram_addra, ram_addrb;
   logic [DATA_WIDTH-1:0] ram_dina, ram_doutb;
   modport slave (
      input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      input  rd_req, rd_addr0, rd_addr1, ram_doutb,
      output wr_gnt, rd_gnt, rd_valid, rd_data,
      output ram_wea, ram_addra, ram_dina, ram_addrb
   );
   modport master (
      output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
      output rd_req, rd_addr0, rd_addr1, ram_doutb,
      input  wr_gnt, rd_gnt, rd_valid, rd_data,
      input  ram_wea, ram_addra, ram_dina, ram_addrb
   );
endinterface

// File: rtl/cache_port_arbiter_rr_burst_arb.sv
// rr_burst_arb: two-requester round-robin arbiter with bounded burst ownership.
//   clk, rst - clock, synchronous active-high reset
//   req_i    - request per requester
//   gnt_o    - combinational one-hot-or-zero grant
module rr_burst_arb
   import cache_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);
   localparam int CW = cnt_w(MAX_BURST);
   arb_st_e       st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lo_q, lo_d;
   logic          keep, w;
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         cnt_q <= '0;
         lo_q  <= PE1;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         lo_q  <= lo_d;
      end
   end
   // lo always names the current owner, so idle contention and rotation
   // collapse into one rule: prefer the other requester, else stay with lo.
   always_comb begin
      keep  = (st_q != IDLE) && req_i[lo_q] && (cnt_q < CW'(MAX_BURST));
      w     = keep ? lo_q : (req_i[~lo_q] ? ~lo_q : lo_q);
      gnt_o = '0;
      st_d  = IDLE;
      cnt_d = '0;
      lo_d  = lo_q;
      if (!rst && req_i[w]) begin
         gnt_o[w] = 1'b1;
         st_d     = w ? OWN1 : OWN0;
         cnt_d    = keep ? cnt_q + CW'(1) : CW'(1);
         lo_d     = w;
      end
   end
endmodule

// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: shares a 1W/1R cache RAM between PE0 and PE1.
//   clk, rst - clock, synchronous active-high reset
//   bus      - PE request/grant/data handshakes and RAM port controls
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 19,
   parameter int MAX_BURST  = 4
) (
   input logic                 clk,
   input logic                 rst,
   cache_port_arbiter_if.slave bus
);
   logic [1:0]            valid_q, valid_d;
   logic                  fwd_q, fwd_d;
   logic [DATA_WIDTH-1:0] fwd_data_q, hold_q;
   rr_burst_arb #(.MAX_BURST(MAX_BURST)) u_wr_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (bus.wr_req),
      .gnt_o (bus.wr_gnt)
   );
   rr_burst_arb #(.MAX_BURST(MAX_BURST)) u_rd_arb (
      .clk   (clk),
      .rst   (rst),
      .req_i (bus.rd_req),
      .gnt_o (bus.rd_gnt)
   );
   always_comb begin
      bus.ram_wea   = |bus.wr_gnt;
      bus.ram_addra = bus.wr_gnt[PE1] ? bus.wr_addr1 : bus.wr_addr0;
      bus.ram_dina  = bus.wr_gnt[PE1] ? bus.wr_data1 : bus.wr_data0;
      bus.ram_addrb = bus.rd_gnt[PE1] ? bus.rd_addr1 : bus.rd_addr0;
      valid_d       = bus.rd_gnt;
      // RAM reads old contents on a same-address write; remember to substitute.
      fwd_d         = (|bus.rd_gnt) && bus.ram_wea && (bus.ram_addra == bus.ram_addrb);
      // A reset arriving with a beat in flight drops that beat.
      bus.rd_valid  = rst ? 2'b00 : valid_q;
      bus.rd_data   = (|valid_q) ? (fwd_q ? fwd_data_q : bus.ram_doutb) : hold_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         fwd_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         fwd_q   <= fwd_d;
      end
      fwd_data_q <= bus.ram_dina;
      if (|bus.rd_valid) hold_q <= bus.rd_data;
   end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: directed checks of arbitration, read latency, forwarding and reset.
module tb_cache_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   cache_port_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(19)) bus ();
   cache_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(19), .MAX_BURST(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   logic [31:0] mem [0:255];
   logic        ld = 1'b0;
   logic [7:0]  ld_a = '0;
   logic [31:0] ld_d = '0;
   always @(posedge clk) begin
      if (ld) mem[ld_a] <= ld_d;
      else if (bus.ram_wea) mem[bus.ram_addra[7:0]] <= bus.ram_dina;
      bus.ram_doutb <= mem[bus.ram_addrb[7:0]];
   end
   int errors = 0;
   int checks = 0;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   logic [1:0] c_exp [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};
   logic [1:0] m_req [11] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11};
   logic [1:0] m_exp [11] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.wr_req = '0; bus.rd_req = '0;
      bus.wr_addr0 = '0; bus.wr_addr1 = '0; bus.wr_data0 = '0; bus.wr_data1 = '0;
      bus.rd_addr0 = '0; bus.rd_addr1 = '0;
      tick();
      ld = 1'b1; ld_a = 8'h10; ld_d = 32'hA5;
      tick();
      ld_a = 8'h11; ld_d = 32'h5A;
      tick();
      ld = 1'b0;
      bus.rd_req = 2'b11; bus.wr_req = 2'b11;
      #1;
      chk("rst_rd_gnt", bus.rd_gnt, 2'b00);
      chk("rst_wr_gnt", bus.wr_gnt, 2'b00);
      chk("rst_valid", bus.rd_valid, 2'b00);
      tick();
      rst = 1'b0; bus.rd_req = '0; bus.wr_req = '0;
      #1;
      chk("idle_wr_gnt", bus.wr_gnt, 2'b00);
      chk("idle_rd_gnt", bus.rd_gnt, 2'b00);
      chk("idle_wea", bus.ram_wea, 1'b0);
      chk("idle_valid", bus.rd_valid, 2'b00);
      tick();
      bus.rd_req = 2'b01; bus.rd_addr0 = 19'h10;
      #1;
      chk("rd1_gnt", bus.rd_gnt, 2'b01);
      chk("rd1_addrb", bus.ram_addrb, 19'h10);
      tick();
      bus.rd_req = '0;
      #1;
      chk("rd1_valid", bus.rd_valid, 2'b01);
      chk("rd1_data", bus.rd_data, 32'hA5);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.rd_req = 2'b11; bus.rd_addr0 = 19'h10; bus.rd_addr1 = 19'h11;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("cont_gnt%0d", i), bus.rd_gnt, c_exp[i]);
         if (i > 0) begin
            chk($sformatf("cont_valid%0d", i), bus.rd_valid, c_exp[i-1]);
            chk($sformatf("cont_data%0d", i), bus.rd_data, c_exp[i-1][1] ? 32'h5A : 32'hA5);
         end
         tick();
      end
      bus.rd_req = '0;
      #1;
      chk("cont_last_valid", bus.rd_valid, 2'b01);
      chk("cont_last_data", bus.rd_data, 32'hA5);
      chk("cont_end_gnt", bus.rd_gnt, 2'b00);
      tick();
      bus.wr_req = 2'b01; bus.wr_addr0 = 19'h20; bus.wr_data0 = 32'h1234;
      bus.rd_req = 2'b10; bus.rd_addr1 = 19'h20;
      #1;
      chk("fwd_wr_gnt", bus.wr_gnt, 2'b01);
      chk("fwd_wea", bus.ram_wea, 1'b1);
      chk("fwd_addra", bus.ram_addra, 19'h20);
      chk("fwd_dina", bus.ram_dina, 32'h1234);
      chk("fwd_rd_gnt", bus.rd_gnt, 2'b10);
      chk("fwd_addrb", bus.ram_addrb, 19'h20);
      tick();
      bus.wr_req = '0; bus.rd_req = '0;
      #1;
      chk("fwd_valid", bus.rd_valid, 2'b10);
      chk("fwd_data", bus.rd_data, 32'h1234);
      tick();
      bus.rd_req = 2'b10;
      #1;
      chk("reread_gnt", bus.rd_gnt, 2'b10);
      tick();
      bus.rd_req = '0;
      #1;
      chk("reread_valid", bus.rd_valid, 2'b10);
      chk("reread_data", bus.rd_data, 32'h1234);
      tick();
      chk("hold_valid", bus.rd_valid, 2'b00);
      chk("hold_data", bus.rd_data, 32'h1234);
      bus.wr_req = 2'b11; bus.wr_addr0 = 19'h30; bus.wr_data0 = 32'h1;
      bus.wr_addr1 = 19'h31; bus.wr_data1 = 32'h2;
      #1;
      chk("wr1_gnt", bus.wr_gnt, 2'b10);
      chk("wr1_addra", bus.ram_addra, 19'h31);
      chk("wr1_dina", bus.ram_dina, 32'h2);
      tick();
      bus.wr_req = '0;
      for (int i = 0; i < 11; i++) begin
         bus.rd_req = m_req[i];
         #1;
         chk($sformatf("mid_gnt%0d", i), bus.rd_gnt, m_exp[i]);
         tick();
      end
      bus.rd_req = 2'b01; bus.rd_addr0 = 19'h10;
      #1;
      chk("rstrd_gnt", bus.rd_gnt, 2'b01);
      tick();
      rst = 1'b1; bus.rd_req = '0; bus.wr_req = 2'b11;
      #1;
      chk("rstrd_valid", bus.rd_valid, 2'b00);
      chk("rstrd_wr_gnt", bus.wr_gnt, 2'b00);
      tick();
      rst = 1'b0; bus.rd_req = 2'b11; bus.wr_req = 2'b11;
      #1;
      chk("post_valid", bus.rd_valid, 2'b00);
      chk("post_rd_gnt", bus.rd_gnt, 2'b01);
      chk("post_wr_gnt", bus.wr_gnt, 2'b01);
      tick();
      bus.rd_req = '0; bus.wr_req = '0;
      tick();
      chk("end_valid", bus.rd_valid, 2'b00);
      chk("end_wea", bus.ram_wea, 1'b0);
      chk("end_gnt", {bus.wr_gnt, bus.rd_gnt}, 4'b0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
